mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-client round-robin arbiter in front of a single memory controller port.
// One command in flight at a time; every wait state is guarded by a timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              c0_req_i,
  input  logic              c0_we_i,
  input  logic [ADDR_W-1:0] c0_addr_i,
  input  logic [DATA_W-1:0] c0_wdata_i,
  input  logic              c1_req_i,
  input  logic              c1_we_i,
  input  logic [ADDR_W-1:0] c1_addr_i,
  input  logic [DATA_W-1:0] c1_wdata_i,
  output logic              c0_done_o,
  output logic              c0_err_o,
  output logic              c1_done_o,
  output logic              c1_err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              active_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_busy_i,
  input  logic              mem_read_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ACC, S_WAIT_DONE, S_WAIT_RD, S_ACK
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_prev_q;
  logic              last_grant_q;
  logic              gnt_q;
  logic              we_q;
  logic              c0_done_q, c0_err_q, c1_done_q, c1_err_q;
  logic              active_q, mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, rdata_q;

  logic              sel_c1, sel_we, in_wait, advance;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the client that was not granted last time wins.
  assign sel_c1    = c1_req_i & (~c0_req_i | ~last_grant_q);
  assign sel_we    = sel_c1 ? c1_we_i    : c0_we_i;
  assign sel_addr  = sel_c1 ? c1_addr_i  : c0_addr_i;
  assign sel_wdata = sel_c1 ? c1_wdata_i : c0_wdata_i;

  assign in_wait = (state_q == S_WAIT_ACC) || (state_q == S_WAIT_DONE) ||
                   (state_q == S_WAIT_RD);

  always_comb begin
    advance = 1'b0;
    unique case (state_q)
      S_WAIT_ACC:  advance = mem_busy_i & ~busy_prev_q;
      S_WAIT_DONE: advance = ~mem_busy_i;
      S_WAIT_RD:   advance = mem_read_ready_i;
      default:     advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      busy_prev_q  <= 1'b0;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      c0_done_q    <= 1'b0;
      c0_err_q     <= 1'b0;
      c1_done_q    <= 1'b0;
      c1_err_q     <= 1'b0;
      active_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      busy_prev_q <= mem_busy_i;
      c0_done_q   <= 1'b0;
      c0_err_q    <= 1'b0;
      c1_done_q   <= 1'b0;
      c1_err_q    <= 1'b0;
      if (in_wait && !advance && (cnt_q == CNT_MAX)) begin
        // Abort: report the failure to the owner and release the port.
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
        active_q    <= 1'b0;
        c0_done_q   <= ~gnt_q;
        c0_err_q    <= ~gnt_q;
        c1_done_q   <= gnt_q;
        c1_err_q    <= gnt_q;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if ((c0_req_i | c1_req_i) & ~mem_busy_i) begin
              state_q      <= S_WAIT_ACC;
              cnt_q        <= '0;
              gnt_q        <= sel_c1;
              last_grant_q <= sel_c1;
              we_q         <= sel_we;
              mem_write_q  <= sel_we;
              mem_read_q   <= ~sel_we;
              mem_addr_q   <= sel_addr;
              mem_wdata_q  <= sel_wdata;
              active_q     <= 1'b1;
            end
          end
          S_WAIT_ACC: begin
            if (advance) begin
              state_q     <= S_WAIT_DONE;
              cnt_q       <= '0;
              mem_read_q  <= 1'b0;
              mem_write_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_WAIT_DONE: begin
            if (advance) begin
              state_q <= we_q ? S_ACK : S_WAIT_RD;
              cnt_q   <= '0;
              if (we_q) begin
                c0_done_q <= ~gnt_q;
                c1_done_q <= gnt_q;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_WAIT_RD: begin
            if (advance) begin
              state_q   <= S_ACK;
              cnt_q     <= '0;
              rdata_q   <= mem_rdata_i;
              c0_done_q <= ~gnt_q;
              c1_done_q <= gnt_q;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_ACK: begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            active_q <= 1'b0;
          end
          default: begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            active_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign c0_done_o   = c0_done_q;
  assign c0_err_o    = c0_err_q;
  assign c1_done_o   = c1_done_q;
  assign c1_err_o    = c1_err_q;
  assign rdata_o     = rdata_q;
  assign active_o    = active_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory controller plus a queue of
// expected completions that each scenario pops as done pulses arrive.
module tb_mem_port_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int TO = 1023;

  logic clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  logic          rst;
  logic          c0_req, c0_we, c1_req, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic          c0_done_o, c0_err_o, c1_done_o, c1_err_o;
  logic [DW-1:0] rdata_o;
  logic          active_o, mem_read_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mdl_busy, force_busy, mem_busy, mem_read_ready;
  logic [DW-1:0] mem_rdata;

  assign mem_busy = mdl_busy | force_busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk50(clk50), .rst(rst),
    .c0_req_i(c0_req), .c0_we_i(c0_we), .c0_addr_i(c0_addr), .c0_wdata_i(c0_wdata),
    .c1_req_i(c1_req), .c1_we_i(c1_we), .c1_addr_i(c1_addr), .c1_wdata_i(c1_wdata),
    .c0_done_o(c0_done_o), .c0_err_o(c0_err_o), .c1_done_o(c1_done_o), .c1_err_o(c1_err_o),
    .rdata_o(rdata_o), .active_o(active_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_busy_i(mem_busy), .mem_read_ready_i(mem_read_ready), .mem_rdata_i(mem_rdata)
  );

  typedef struct {
    logic          client;
    logic          err;
    logic          is_rd;
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Memory controller model knobs.
  int            mdl_busy_len = 2;
  int            mdl_rd_delay = 2;
  logic          mdl_never = 1'b0;
  logic [DW-1:0] mdl_rdata = '0;

  initial begin
    logic rd;
    mdl_busy = 1'b0;
    mem_read_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk50);
      if (!mdl_never && !mdl_busy && (mem_read_o || mem_write_o)) begin
        rd = mem_read_o;
        mdl_busy = 1'b1;
        repeat (mdl_busy_len) @(negedge clk50);
        mdl_busy = 1'b0;
        if (rd) begin
          repeat (mdl_rd_delay) @(negedge clk50);
          mem_rdata = mdl_rdata;
          mem_read_ready = 1'b1;
          @(negedge clk50);
          mem_read_ready = 1'b0;
        end
      end
    end
  end

  function automatic logic [3:0] exp_vec(exp_t e);
    return {~e.client, e.client, e.err & ~e.client, e.err & e.client};
  endfunction

  // Waits for the next done pulse, recording what the memory port did meanwhile.
  task automatic wait_done(input int budget, output logic to, output logic [3:0] dv,
                           output int nstb, output logic [AW-1:0] a,
                           output logic [DW-1:0] wd, output int lat,
                           output logic wr_at_done, output logic act_at_done,
                           output logic both);
    logic pstb;
    int   sidx;
    to = 1'b1; dv = '0; nstb = 0; a = '0; wd = '0; lat = 0;
    wr_at_done = 1'b0; act_at_done = 1'b0; both = 1'b0; sidx = 0;
    pstb = mem_read_o | mem_write_o;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk50);
      if (mem_read_o && mem_write_o) both = 1'b1;
      if ((mem_read_o | mem_write_o) && !pstb) begin
        nstb++;
        if (nstb == 1) begin
          a = mem_addr_o; wd = mem_wdata_o; sidx = i;
        end
      end
      pstb = mem_read_o | mem_write_o;
      if (c0_done_o | c1_done_o) begin
        dv = {c0_done_o, c1_done_o, c0_err_o, c1_err_o};
        lat = i - sidx;
        wr_at_done = mem_write_o;
        act_at_done = active_o;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
    force_busy = 1'b0;
    repeat (3) @(negedge clk50);
    rst = 1'b0;
    @(negedge clk50);
    checks++; if (active_o !== 1'b0) begin errors++; $display("FAIL reset_active got %b expected 0", active_o); end
    checks++; if ({mem_read_o, mem_write_o} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b expected 00", {mem_read_o, mem_write_o}); end
    checks++; if ({c0_done_o, c1_done_o, c0_err_o, c1_err_o} !== 4'b0) begin errors++; $display("FAIL reset_done_err got %b expected 0000", {c0_done_o, c1_done_o, c0_err_o, c1_err_o}); end
    checks++; if (rdata_o !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h expected 0000", rdata_o); end
    checks++; if (mem_addr_o !== 24'h0) begin errors++; $display("FAIL reset_addr got %h expected 000000", mem_addr_o); end
    checks++; if (mem_wdata_o !== 16'h0) begin errors++; $display("FAIL reset_wdata got %h expected 0000", mem_wdata_o); end
  endtask

  task automatic test_alternate();
    logic to, wr, act, both; logic [3:0] dv; int nstb, lat;
    logic [AW-1:0] a; logic [DW-1:0] wd; exp_t e;
    for (int k = 0; k < 4; k++)
      sb.push_back('{client: k[0], err: 1'b0, is_rd: 1'b0, rdata: '0,
                     addr: (k[0] ? 24'h000200 : 24'h000100)});
    c0_we = 1; c0_addr = 24'h000100; c0_wdata = 16'h0A0A; c0_req = 1;
    c1_we = 1; c1_addr = 24'h000200; c1_wdata = 16'h0B0B; c1_req = 1;
    for (int k = 0; k < 4; k++) begin
      wait_done(200, to, dv, nstb, a, wd, lat, wr, act, both);
      if (k == 3) begin c0_req = 0; c1_req = 0; end
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL alt_timeout got no done expected done %0d", k); end
      else begin
        e = sb.pop_front();
        checks++; if (dv !== exp_vec(e)) begin errors++; $display("FAIL alt_grant_%0d got %b expected %b", k, dv, exp_vec(e)); end
        checks++; if (a !== e.addr) begin errors++; $display("FAIL alt_addr_%0d got %h expected %h", k, a, e.addr); end
      end
    end
  endtask

  task automatic test_write();
    logic to, wr, act, both; logic [3:0] dv; int nstb, lat;
    logic [AW-1:0] a; logic [DW-1:0] wd; exp_t e;
    mdl_busy_len = 2;
    sb.push_back('{client: 1'b0, err: 1'b0, is_rd: 1'b0, rdata: '0, addr: 24'h000010});
    c0_we = 1; c0_addr = 24'h000010; c0_wdata = 16'h1234; c0_req = 1;
    wait_done(200, to, dv, nstb, a, wd, lat, wr, act, both);
    c0_req = 0;
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL wr_timeout got no done expected done"); end
    else begin
      e = sb.pop_front();
      checks++; if (dv !== exp_vec(e)) begin errors++; $display("FAIL wr_done_err got %b expected %b", dv, exp_vec(e)); end
      checks++; if (nstb !== 1) begin errors++; $display("FAIL wr_strobe_count got %0d expected 1", nstb); end
      checks++; if (a !== e.addr) begin errors++; $display("FAIL wr_addr got %h expected %h", a, e.addr); end
      checks++; if (wd !== 16'h1234) begin errors++; $display("FAIL wr_wdata got %h expected 1234", wd); end
      checks++; if (both !== 1'b0) begin errors++; $display("FAIL wr_both_strobes got %b expected 0", both); end
      @(negedge clk50);
      checks++; if ({c0_done_o, c1_done_o} !== 2'b00) begin errors++; $display("FAIL wr_single_pulse got %b expected 00", {c0_done_o, c1_done_o}); end
      checks++; if (rdata_o !== 16'h0) begin errors++; $display("FAIL wr_rdata_kept got %h expected 0000", rdata_o); end
    end
  endtask

  task automatic test_read();
    logic to, wr, act, both; logic [3:0] dv; int nstb, lat;
    logic [AW-1:0] a; logic [DW-1:0] wd; exp_t e;
    mdl_rd_delay = 2; mdl_rdata = 16'hBEEF;
    sb.push_back('{client: 1'b1, err: 1'b0, is_rd: 1'b1, rdata: 16'hBEEF, addr: 24'h800005});
    c1_we = 0; c1_addr = 24'h800005; c1_req = 1;
    wait_done(200, to, dv, nstb, a, wd, lat, wr, act, both);
    c1_req = 0;
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL rd_timeout got no done expected done"); end
    else begin
      e = sb.pop_front();
      checks++; if (dv !== exp_vec(e)) begin errors++; $display("FAIL rd_done_err got %b expected %b", dv, exp_vec(e)); end
      checks++; if (rdata_o !== e.rdata) begin errors++; $display("FAIL rd_data got %h expected %h", rdata_o, e.rdata); end
      checks++; if (a !== e.addr) begin errors++; $display("FAIL rd_addr got %h expected %h", a, e.addr); end
    end
  endtask

  task automatic test_timeout();
    logic to, wr, act, both; logic [3:0] dv; int nstb, lat;
    logic [AW-1:0] a; logic [DW-1:0] wd; exp_t e;
    mdl_never = 1'b1;
    sb.push_back('{client: 1'b0, err: 1'b1, is_rd: 1'b0, rdata: '0, addr: 24'h0000AA});
    c0_we = 1; c0_addr = 24'h0000AA; c0_wdata = 16'h5555; c0_req = 1;
    wait_done(TO + 200, to, dv, nstb, a, wd, lat, wr, act, both);
    c0_req = 0;
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL to_no_abort got no done expected done"); end
    else begin
      e = sb.pop_front();
      checks++; if (dv !== exp_vec(e)) begin errors++; $display("FAIL to_done_err got %b expected %b", dv, exp_vec(e)); end
      checks++; if (lat !== TO + 1) begin errors++; $display("FAIL to_latency got %0d expected %0d", lat, TO + 1); end
      checks++; if (wr !== 1'b0) begin errors++; $display("FAIL to_strobe_drop got %b expected 0", wr); end
      checks++; if (act !== 1'b0) begin errors++; $display("FAIL to_active got %b expected 0", act); end
      checks++; if (rdata_o !== 16'hBEEF) begin errors++; $display("FAIL to_rdata_kept got %h expected beef", rdata_o); end
    end
    mdl_never = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic to, wr, act, both, seen; logic [3:0] dv; int nstb, lat, ndone;
    logic [AW-1:0] a; logic [DW-1:0] wd; exp_t e;
    mdl_rd_delay = 20; mdl_rdata = 16'h1111;
    c1_we = 0; c1_addr = 24'h000777; c1_req = 1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk50);
      if (mem_busy) begin seen = 1'b1; break; end
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk50);
      if (!mem_busy) break;
    end
    repeat (3) @(negedge clk50);
    rst = 1'b1; c1_req = 0;
    @(negedge clk50);
    rst = 1'b0;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rm_busy_seen got %b expected 1", seen); end
    checks++; if (active_o !== 1'b0) begin errors++; $display("FAIL rm_active got %b expected 0", active_o); end
    checks++; if ({mem_read_o, mem_write_o, c0_done_o, c1_done_o} !== 4'b0) begin errors++; $display("FAIL rm_outputs got %b expected 0000", {mem_read_o, mem_write_o, c0_done_o, c1_done_o}); end
    ndone = 0;
    repeat (30) begin
      @(negedge clk50);
      if (c0_done_o | c1_done_o) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rm_no_done got %0d expected 0", ndone); end
    checks++; if (rdata_o !== 16'h0) begin errors++; $display("FAIL rm_rdata got %h expected 0000", rdata_o); end
    mdl_rd_delay = 2; mdl_rdata = 16'h5A5A;
    sb.push_back('{client: 1'b1, err: 1'b0, is_rd: 1'b1, rdata: 16'h5A5A, addr: 24'h000123});
    c1_addr = 24'h000123; c1_req = 1;
    wait_done(200, to, dv, nstb, a, wd, lat, wr, act, both);
    c1_req = 0;
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL rm_retry_timeout got no done expected done"); end
    else begin
      e = sb.pop_front();
      checks++; if (dv !== exp_vec(e)) begin errors++; $display("FAIL rm_retry_done got %b expected %b", dv, exp_vec(e)); end
      checks++; if (rdata_o !== e.rdata) begin errors++; $display("FAIL rm_retry_rdata got %h expected %h", rdata_o, e.rdata); end
      checks++; if (a !== e.addr) begin errors++; $display("FAIL rm_retry_addr got %h expected %h", a, e.addr); end
    end
  endtask

  task automatic test_busy_block();
    logic to, wr, act, both; logic [3:0] dv; int nstb, lat, early;
    logic [AW-1:0] a; logic [DW-1:0] wd; exp_t e;
    force_busy = 1'b1;
    sb.push_back('{client: 1'b0, err: 1'b0, is_rd: 1'b0, rdata: '0, addr: 24'h0000CC});
    c0_we = 1; c0_addr = 24'h0000CC; c0_wdata = 16'h0C0C; c0_req = 1;
    early = 0;
    repeat (10) begin
      @(negedge clk50);
      if (mem_read_o | mem_write_o | active_o) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL bb_blocked got %0d expected 0", early); end
    force_busy = 1'b0;
    @(negedge clk50);
    checks++; if (mem_write_o !== 1'b1) begin errors++; $display("FAIL bb_grant_next got %b expected 1", mem_write_o); end
    checks++; if (mem_addr_o !== 24'h0000CC) begin errors++; $display("FAIL bb_addr got %h expected 0000cc", mem_addr_o); end
    wait_done(200, to, dv, nstb, a, wd, lat, wr, act, both);
    c0_req = 0;
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL bb_timeout got no done expected done"); end
    else begin
      e = sb.pop_front();
      checks++; if (dv !== exp_vec(e)) begin errors++; $display("FAIL bb_done got %b expected %b", dv, exp_vec(e)); end
    end
  endtask

  initial begin
    force_busy = 1'b0;
    rst = 1'b1;
    test_reset();
    test_alternate();
    test_write();
    test_read();
    test_timeout();
    test_rst_mid();
    test_busy_block();
    repeat (5) @(negedge clk50);
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_leftover got %0d expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
